// File: rtl/sr_pkg.sv
// Shared definitions for the parametrised shift engine: op-codes and FSM state encoding.
package sr_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_SRA  = 3'b110;
  localparam logic [2:0] OP_SIN  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sr_state_e;

endpackage

// File: rtl/sr_step_unit.sv
// Combinational single-step shifter shared by the single-step and multi-step paths.
module sr_step_unit
  import sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] srdata_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] d_o,
  output logic             out_bit_o,
  output logic             flag_we_o
);

  always_comb begin
    d_o       = d_i;
    out_bit_o = 1'b0;
    flag_we_o = 1'b0;
    case (op_i)
      OP_SRL: begin
        d_o       = {1'b0, d_i[WIDTH-1:1]};
        out_bit_o = d_i[0];
        flag_we_o = 1'b1;
      end
      OP_SLL: begin
        d_o       = {d_i[WIDTH-2:0], 1'b0};
        out_bit_o = d_i[WIDTH-1];
        flag_we_o = 1'b1;
      end
      OP_LOAD: d_o = srdata_i;
      OP_ROR: begin
        d_o       = {d_i[0], d_i[WIDTH-1:1]};
        out_bit_o = d_i[0];
        flag_we_o = 1'b1;
      end
      OP_ROL: begin
        d_o       = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
        out_bit_o = d_i[WIDTH-1];
        flag_we_o = 1'b1;
      end
      OP_SRA: begin
        d_o       = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
        out_bit_o = d_i[0];
        flag_we_o = 1'b1;
      end
      OP_SIN: begin
        d_o       = {serial_i, d_i[WIDTH-1:1]};
        out_bit_o = d_i[0];
        flag_we_o = 1'b1;
      end
      default: d_o = d_i;
    endcase
  end

endmodule

// File: rtl/param_shift_engine.sv
// WIDTH-bit shift/serialiser engine with single-step and counted multi-step operation.
module param_shift_engine
  import sr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             sr_clk,
  input  logic             sr_rst,
  input  logic             sr_en,
  input  logic [2:0]       sr_op,
  input  logic             sr_start,
  input  logic [CNT_W-1:0] sr_count,
  input  logic [WIDTH-1:0] srdata_in,
  input  logic             sr_serial_in,
  output logic [WIDTH-1:0] srdata_out,
  output logic             flag,
  output logic             busy,
  output logic             done
);

  sr_state_e        state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             flag_q, flag_d;
  logic             done_q, done_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;
  logic             step_flag_we;
  logic             do_step;

  // A running sequence uses its latched op; idle steps follow sr_op directly.
  assign step_op = (state_q == ST_RUN) ? op_q : sr_op;

  sr_step_unit #(.WIDTH(WIDTH)) u_step (
    .op_i      (step_op),
    .d_i       (data_q),
    .srdata_i  (srdata_in),
    .serial_i  (sr_serial_in),
    .d_o       (step_data),
    .out_bit_o (step_bit),
    .flag_we_o (step_flag_we)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    data_d  = data_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    do_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sr_en) begin
          if (sr_start) begin
            op_d = sr_op;
            if (sr_count == '0) begin
              done_d = 1'b1;
            end else begin
              do_step = 1'b1;
              rem_d   = sr_count - CNT_W'(1);
              if (sr_count == CNT_W'(1)) done_d = 1'b1;
              else state_d = ST_RUN;
            end
          end else begin
            do_step = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (sr_en) begin
          do_step = 1'b1;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_step) begin
      data_d = step_data;
      if (step_flag_we) flag_d = step_bit;
    end
  end

  always_ff @(posedge sr_clk or posedge sr_rst) begin
    if (sr_rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign srdata_out = data_q;
  assign flag       = flag_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;

endmodule

// File: tb/tb_param_shift_engine.sv
// Directed scoreboard bench for param_shift_engine (WIDTH=8, CNT_W=4).
module tb_param_shift_engine;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] op;
  logic       start;
  logic [3:0] cnt;
  logic [7:0] din;
  logic       sin;
  logic [7:0] dout;
  logic       flag;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  typedef struct packed {
    logic [7:0] data;
    logic       flag;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  param_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .sr_clk       (clk),
    .sr_rst       (rst),
    .sr_en        (en),
    .sr_op        (op),
    .sr_start     (start),
    .sr_count     (cnt),
    .srdata_in    (din),
    .sr_serial_in (sin),
    .srdata_out   (dout),
    .flag         (flag),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".data"}, dout, e.data);
    chk({tag, ".flag"}, {7'd0, flag}, {7'd0, e.flag});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, e.done});
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, then pop and compare.
  task automatic step(input string tag, input logic e, input logic [2:0] o, input logic s,
                      input logic [3:0] c, input logic [7:0] d, input logic si,
                      input logic [7:0] ed, input logic ef, input logic eb, input logic edn);
    exp_t  e_pop;
    string t_pop;
    en = e; op = o; start = s; cnt = c; din = d; sin = si;
    exp_q.push_back('{data: ed, flag: ef, busy: eb, done: edn});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e_pop = exp_q.pop_front();
      t_pop = tag_q.pop_front();
      chk_all(t_pop, e_pop);
    end
  endtask

  task automatic async_reset_check(input string tag);
    #3 rst = 1'b1;
    #1;
    chk_all(tag, '{data: 8'h00, flag: 1'b0, busy: 1'b0, done: 1'b0});
    #1 rst = 1'b0;
  endtask

  initial begin
    logic signed [7:0] sra_v;
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; op = 3'd0; start = 1'b0; cnt = 4'd0; din = 8'h00; sin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", '{data: 8'h00, flag: 1'b0, busy: 1'b0, done: 1'b0});
    rst = 1'b0;

    // Single-step operations
    step("ld_a5",  1, 3'b011, 0, 0, 8'hA5, 0, 8'hA5, 0, 0, 0);
    step("srl",    1, 3'b001, 0, 0, 8'h00, 0, 8'h52, 1, 0, 0);
    step("ld_81",  1, 3'b011, 0, 0, 8'h81, 0, 8'h81, 1, 0, 0);
    step("sra",    1, 3'b110, 0, 0, 8'h00, 0, 8'hC0, 1, 0, 0);
    step("ld_01",  1, 3'b011, 0, 0, 8'h01, 0, 8'h01, 1, 0, 0);
    step("ror",    1, 3'b100, 0, 0, 8'h00, 0, 8'h80, 1, 0, 0);
    step("rol",    1, 3'b101, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0);
    step("hold",   1, 3'b000, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0);
    step("en0",    0, 3'b001, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0);
    step("st_en0", 0, 3'b010, 1, 3, 8'h00, 0, 8'h01, 1, 0, 0);

    // Three-step left shift
    step("sq_ld",  1, 3'b011, 0, 0, 8'h96, 0, 8'h96, 1, 0, 0);
    step("sq_s1",  1, 3'b010, 1, 3, 8'h00, 0, 8'h2C, 1, 1, 0);
    step("sq_s2",  1, 3'b000, 0, 0, 8'h00, 0, 8'h58, 0, 1, 0);
    step("sq_s3",  1, 3'b000, 0, 0, 8'h00, 0, 8'hB0, 0, 0, 1);
    step("sq_end", 0, 3'b000, 0, 0, 8'h00, 0, 8'hB0, 0, 0, 0);

    // Same sequence with stalls and an ignored second start
    step("st_ld",  1, 3'b011, 0, 0, 8'h96, 0, 8'h96, 0, 0, 0);
    step("st_s1",  1, 3'b010, 1, 3, 8'h00, 0, 8'h2C, 1, 1, 0);
    step("st_w1",  0, 3'b000, 0, 0, 8'h00, 0, 8'h2C, 1, 1, 0);
    step("st_w2",  0, 3'b011, 1, 7, 8'h00, 0, 8'h2C, 1, 1, 0);
    step("st_s2",  1, 3'b001, 1, 7, 8'h00, 0, 8'h58, 0, 1, 0);
    step("st_s3",  1, 3'b011, 0, 0, 8'hFF, 0, 8'hB0, 0, 0, 1);
    step("st_end", 0, 3'b000, 0, 0, 8'h00, 0, 8'hB0, 0, 0, 0);

    // Serial-in shifts, zero and one step counts, back-to-back done
    step("si_ld",  1, 3'b011, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    step("si_1",   1, 3'b111, 0, 0, 8'h00, 1, 8'h80, 0, 0, 0);
    step("si_2",   1, 3'b111, 0, 0, 8'h00, 1, 8'hC0, 0, 0, 0);
    step("si_3",   1, 3'b111, 0, 0, 8'h00, 1, 8'hE0, 0, 0, 0);
    step("si_4",   1, 3'b111, 0, 0, 8'h00, 1, 8'hF0, 0, 0, 0);
    step("cnt0",   1, 3'b001, 1, 0, 8'h00, 0, 8'hF0, 0, 0, 1);
    step("cnt0_e", 0, 3'b001, 0, 0, 8'h00, 0, 8'hF0, 0, 0, 0);
    step("cnt1_a", 1, 3'b001, 1, 1, 8'h00, 0, 8'h78, 0, 0, 1);
    step("cnt1_b", 1, 3'b001, 1, 1, 8'h00, 0, 8'h3C, 0, 0, 1);

    // Reset in the middle of a seven-step sequence
    step("rm_ld",  1, 3'b011, 0, 0, 8'hFF, 0, 8'hFF, 0, 0, 0);
    step("rm_s1",  1, 3'b001, 1, 7, 8'h00, 0, 8'h7F, 1, 1, 0);
    step("rm_s2",  1, 3'b000, 0, 0, 8'h00, 0, 8'h3F, 1, 1, 0);
    step("rm_s3",  1, 3'b000, 0, 0, 8'h00, 0, 8'h1F, 1, 1, 0);
    async_reset_check("rst_mid");
    step("rc_ld",  1, 3'b011, 0, 0, 8'h81, 0, 8'h81, 0, 0, 0);
    step("rc_s1",  1, 3'b101, 1, 2, 8'h00, 0, 8'h03, 1, 1, 0);
    step("rc_s2",  1, 3'b000, 0, 0, 8'h00, 0, 8'h06, 0, 0, 1);

    // Asynchronous reset while holding 0xFF with busy high
    step("rb_ld",  1, 3'b011, 0, 0, 8'hFF, 0, 8'hFF, 0, 0, 0);
    step("rb_st",  1, 3'b000, 1, 5, 8'h00, 0, 8'hFF, 0, 1, 0);
    async_reset_check("rst_busy");

    // Arithmetic right shift past WIDTH saturates to all-sign
    step("sa_ld",  1, 3'b011, 0, 0, 8'h80, 0, 8'h80, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      sra_v = 8'sh80 >>> k;
      step($sformatf("sa_%0d", k), 1, (k == 1) ? 3'b110 : 3'b000, (k == 1), 4'd9, 8'h00, 0,
           sra_v, (k >= 8), (k < 9), (k == 9));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
